// File: rtl/axi4l_rom_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read slave among N requesters.
// One read in flight; registered address, buffered response, R timeout.
module axi4l_rom_read_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr_i,
   input  logic [NUM_MASTERS-1:0]        m_arvalid_i,
   output logic [NUM_MASTERS-1:0]        m_arready_o,
   output logic [DATA_WIDTH-1:0]         m_rdata_o,
   output logic [1:0]                    m_rresp_o,
   output logic [NUM_MASTERS-1:0]        m_rvalid_o,
   input  logic [NUM_MASTERS-1:0]        m_rready_i,
   output logic [ADDR_WIDTH-1:0]         s_araddr_o,
   output logic                          s_arvalid_o,
   input  logic                          s_arready_i,
   input  logic [DATA_WIDTH-1:0]         s_rdata_i,
   input  logic [1:0]                    s_rresp_i,
   input  logic                          s_rvalid_i,
   output logic                          s_rready_o,
   output logic                          timeout_o
);

   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int GW1 = GW + 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] TO_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_RESP,
      S_DRAIN
   } state_e;

   state_e                state_q, state_d;
   logic [GW-1:0]         gnt_q, gnt_d;
   logic [GW-1:0]         last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  drain_q, drain_d;

   logic [GW-1:0]         win;
   logic                  win_vld;

   assign m_rdata_o  = rdata_q;
   assign m_rresp_o  = rresp_q;
   assign s_araddr_o = addr_q;

   // Round-robin search starting one past the last granted master.
   always_comb begin
      logic [GW1-1:0] j;
      j       = '0;
      win     = '0;
      win_vld = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         j = {1'b0, last_q} + GW1'(i + 1);
         if (j >= GW1'(NUM_MASTERS)) begin
            j = j - GW1'(NUM_MASTERS);
         end
         if (!win_vld && m_arvalid_i[j[GW-1:0]]) begin
            win_vld = 1'b1;
            win     = j[GW-1:0];
         end
      end
   end

   // Transaction FSM: next state, register updates and handshake outputs.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      addr_d      = addr_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      m_arready_o = '0;
      m_rvalid_o  = '0;
      s_arvalid_o = 1'b0;
      s_rready_o  = 1'b0;
      timeout_o   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // rst_ni gate keeps arready low while reset is held
            if (win_vld && rst_ni) begin
               m_arready_o[win] = 1'b1;
               addr_d  = m_araddr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
               gnt_d   = win;
               last_d  = win;
               state_d = S_AR;
            end
         end
         S_AR: begin
            s_arvalid_o = 1'b1;
            if (s_arready_i) begin
               cnt_d   = '0;
               state_d = S_R;
            end
         end
         S_R: begin
            s_rready_o = 1'b1;
            if (s_rvalid_i) begin
               rdata_d = s_rdata_i;
               rresp_d = s_rresp_i;
               state_d = S_RESP;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               rdata_d   = '0;
               rresp_d   = 2'b10;
               drain_d   = 1'b1;
               timeout_o = 1'b1;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            m_rvalid_o[gnt_q] = 1'b1;
            s_rready_o        = drain_q;
            if (drain_q && s_rvalid_i) begin
               drain_d = 1'b0;
            end
            if (m_rready_i[gnt_q]) begin
               if (drain_q && !s_rvalid_i) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            s_rready_o = 1'b1;
            if (s_rvalid_i) begin
               drain_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         last_q  <= GW'(NUM_MASTERS - 1);
         addr_q  <= '0;
         rdata_q <= '0;
         rresp_q <= '0;
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

endmodule

// File: tb/tb_axi4l_rom_read_arbiter.sv
// Directed bench for axi4l_rom_read_arbiter: transaction table plus
// contention, timeout/drain and mid-transaction reset sequences.
module tb_axi4l_rom_read_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [NM*AW-1:0] m_araddr_i;
   logic [NM-1:0]   m_arvalid_i;
   logic [NM-1:0]   m_arready_o;
   logic [DW-1:0]   m_rdata_o;
   logic [1:0]      m_rresp_o;
   logic [NM-1:0]   m_rvalid_o;
   logic [NM-1:0]   m_rready_i;
   logic [AW-1:0]   s_araddr_o;
   logic            s_arvalid_o;
   logic            s_arready_i;
   logic [DW-1:0]   s_rdata_i;
   logic [1:0]      s_rresp_i;
   logic            s_rvalid_i;
   logic            s_rready_o;
   logic            timeout_o;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int to_pulses = 0;

   axi4l_rom_read_arbiter #(
      .NUM_MASTERS(NM),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .m_araddr_i(m_araddr_i),
      .m_arvalid_i(m_arvalid_i),
      .m_arready_o(m_arready_o),
      .m_rdata_o(m_rdata_o),
      .m_rresp_o(m_rresp_o),
      .m_rvalid_o(m_rvalid_o),
      .m_rready_i(m_rready_i),
      .s_araddr_o(s_araddr_o),
      .s_arvalid_o(s_arvalid_o),
      .s_arready_i(s_arready_i),
      .s_rdata_i(s_rdata_i),
      .s_rresp_i(s_rresp_i),
      .s_rvalid_i(s_rvalid_i),
      .s_rready_o(s_rready_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (timeout_o === 1'b1) to_pulses <= to_pulses + 1;
   end

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      int          ar_wait;
      int          r_wait;
      int          rr_wait;
      bit          other;
      logic [1:0]  exp_gnt;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
      int          exp_lat;
   } vec_t;

   vec_t vec [8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_arready"}, m_arready_o, 0);
      chk({tag, "_rvalid"}, m_rvalid_o, 0);
      chk({tag, "_s_arvalid"}, s_arvalid_o, 0);
      chk({tag, "_s_rready"}, s_rready_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
      chk({tag, "_rdata"}, m_rdata_o, 0);
      chk({tag, "_rresp"}, m_rresp_o, 0);
      chk({tag, "_s_araddr"}, s_araddr_o, 0);
   endtask

   // One complete read; starts and ends just after a rising edge in IDLE.
   task automatic run_txn(input vec_t v);
      int t0;
      int om;
      om = 1 - v.m;
      m_arvalid_i[v.m] = 1'b1;
      m_araddr_i[v.m*AW +: AW] = v.addr;
      if (v.other) m_arvalid_i[om] = 1'b1;
      m_rready_i  = '0;
      s_arready_i = 1'b0;
      s_rvalid_i  = 1'b0;
      s_rresp_i   = v.resp;
      @(negedge clk);
      chk("grant", m_arready_o, v.exp_gnt);
      t0 = cyc;
      tick();
      m_arvalid_i[v.m] = 1'b0;
      for (int i = 0; i <= v.ar_wait; i++) begin
         s_arready_i = (i == v.ar_wait);
         @(negedge clk);
         chk("s_arvalid", s_arvalid_o, 1);
         chk("s_araddr", s_araddr_o, v.addr);
         if (v.other) chk("hold_ar", m_arready_o, 0);
         tick();
      end
      s_arready_i = 1'b0;
      for (int i = 0; i <= v.r_wait; i++) begin
         s_rvalid_i = (i == v.r_wait);
         s_rdata_i  = (i == v.r_wait) ? v.data : ~v.data;
         @(negedge clk);
         chk("s_rready", s_rready_o, 1);
         chk("no_timeout", timeout_o, 0);
         chk("rvalid_in_r", m_rvalid_o, 0);
         tick();
      end
      s_rvalid_i = 1'b0;
      s_rdata_i  = 32'h5A5A_0000;
      for (int i = 0; i <= v.rr_wait; i++) begin
         m_rready_i = (i == v.rr_wait) ? v.exp_gnt : 2'b00;
         @(negedge clk);
         if (i == 0) chk("latency", cyc - t0, v.exp_lat);
         chk("m_rvalid", m_rvalid_o, v.exp_gnt);
         chk("m_rdata", m_rdata_o, v.exp_rdata);
         chk("m_rresp", m_rresp_o, v.exp_rresp);
         chk("s_rready_resp", s_rready_o, 0);
         if (v.other) chk("hold_resp", m_arready_o, 0);
         tick();
      end
      m_rready_i = '0;
      if (v.other) m_arvalid_i[om] = 1'b0;
   endtask

   // Request, immediate AR accept, then eight silent R cycles.
   task automatic to_prefix(input int m, input logic [31:0] a);
      m_arvalid_i[m] = 1'b1;
      m_araddr_i[m*AW +: AW] = a;
      s_arready_i = 1'b1;
      @(negedge clk);
      chk("to_grant", m_arready_o, (m == 0) ? 2'b01 : 2'b10);
      tick();
      m_arvalid_i[m] = 1'b0;
      @(negedge clk);
      chk("to_s_arvalid", s_arvalid_o, 1);
      tick();
      s_arready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("to_pulse", timeout_o, (i == 7));
         tick();
      end
   endtask

   initial begin
      //         m  addr          data          rsp    ar r rr oth gnt    rdata         rrsp  lat
      vec[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 2'b01, 32'hDEAD_BEEF, 2'b00, 3};
      vec[1] = '{1, 32'h0000_0020, 32'hCAFE_F00D, 2'b00, 5, 0, 3, 1, 2'b10, 32'hCAFE_F00D, 2'b00, 8};
      vec[2] = '{0, 32'h0000_0030, 32'h1234_5678, 2'b11, 0, 2, 0, 0, 2'b01, 32'h1234_5678, 2'b11, 5};
      vec[3] = '{1, 32'h0000_0044, 32'hA5A5_A5A5, 2'b10, 1, 3, 1, 0, 2'b10, 32'hA5A5_A5A5, 2'b10, 7};
      vec[4] = '{0, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 2'b01, 2, 7, 0, 0, 2'b01, 32'h0F0F_0F0F, 2'b01, 12};
      vec[5] = '{1, 32'h0000_0090, 32'h0000_600D, 2'b00, 0, 0, 0, 0, 2'b10, 32'h0000_600D, 2'b00, 3};
      vec[6] = '{0, 32'h0000_00A4, 32'h1122_3344, 2'b00, 0, 1, 0, 0, 2'b01, 32'h1122_3344, 2'b00, 4};
      vec[7] = '{0, 32'h0000_00C4, 32'h5566_7788, 2'b00, 0, 0, 2, 1, 2'b01, 32'h5566_7788, 2'b00, 3};

      rst_ni      = 1'b0;
      m_araddr_i  = '0;
      m_arvalid_i = 2'b11;
      m_rready_i  = '0;
      s_arready_i = 1'b0;
      s_rdata_i   = '0;
      s_rresp_i   = '0;
      s_rvalid_i  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      m_arvalid_i = '0;
      tick();
      rst_ni = 1'b1;

      // contention: both masters always requesting, slave answers at once
      m_arvalid_i = 2'b11;
      s_arready_i = 1'b1;
      s_rvalid_i  = 1'b1;
      m_rready_i  = 2'b11;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] eg;
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         s_rdata_i = 32'h100 + k;
         @(negedge clk);
         chk("rr_grant", m_arready_o, eg);
         tick();
         @(negedge clk);
         chk("rr_s_arvalid", s_arvalid_o, 1);
         tick();
         @(negedge clk);
         chk("rr_s_rready", s_rready_o, 1);
         tick();
         @(negedge clk);
         chk("rr_rvalid", m_rvalid_o, eg);
         chk("rr_rdata", m_rdata_o, 32'h100 + k);
         tick();
      end
      m_arvalid_i = '0;
      s_arready_i = 1'b0;
      s_rvalid_i  = 1'b0;
      m_rready_i  = '0;

      for (int i = 0; i < 5; i++) run_txn(vec[i]);
      chk("no_pulses_table", to_pulses, 0);

      // timeout, SLVERR to master, drain a very late response
      to_prefix(0, 32'h0000_0080);
      m_rready_i = 2'b01;
      @(negedge clk);
      chk("to_rvalid", m_rvalid_o, 2'b01);
      chk("to_rdata", m_rdata_o, 0);
      chk("to_rresp", m_rresp_o, 2'b10);
      chk("to_s_rready", s_rready_o, 1);
      tick();
      m_rready_i  = '0;
      m_arvalid_i = 2'b10;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("drain_s_rready", s_rready_o, 1);
         chk("drain_no_grant", m_arready_o, 0);
         chk("drain_no_ar", s_arvalid_o, 0);
         tick();
      end
      s_rvalid_i = 1'b1;
      s_rdata_i  = 32'h0000_0BAD;
      @(negedge clk);
      chk("drain_take", s_rready_o, 1);
      tick();
      s_rvalid_i = 1'b0;
      run_txn(vec[5]);
      chk("one_pulse", to_pulses, 1);

      // late response in the same cycle as the master handshake
      to_prefix(0, 32'h0000_00A0);
      m_rready_i = 2'b01;
      s_rvalid_i = 1'b1;
      @(negedge clk);
      chk("late_rvalid", m_rvalid_o, 2'b01);
      chk("late_s_rready", s_rready_o, 1);
      tick();
      m_rready_i = '0;
      s_rvalid_i = 1'b0;
      @(negedge clk);
      chk("late_idle", s_rready_o, 0);
      tick();
      run_txn(vec[6]);
      chk("two_pulses", to_pulses, 2);

      // reset while waiting in R
      m_arvalid_i = 2'b01;
      m_araddr_i[AW-1:0] = 32'h0000_00C0;
      s_arready_i = 1'b1;
      tick();
      m_arvalid_i = '0;
      tick();
      s_arready_i = 1'b0;
      tick();
      rst_ni = 1'b0;
      #1;
      chk_zero("midreset");
      tick();
      rst_ni = 1'b1;
      run_txn(vec[7]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
